// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment display scanner with per-digit register file,
// per-slot PWM brightness and registered anode/cathode/dp drive.
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV    = 131072,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  localparam int unsigned IW            = $clog2(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_sel,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  input  logic [3:0]            bright,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode,
  output logic                  dp,
  output logic [IW-1:0]         scan_idx,
  output logic                  frame_tick
);

  // Slot counter is kept as {sub-period index, cycle within sub-period} so
  // REFRESH_DIV only needs to be a multiple of 16, not a power of two.
  localparam int unsigned SUB_LEN = REFRESH_DIV / 16;
  localparam int unsigned SW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_INV  = {7{SEG_ACTIVE_LOW}};

  logic [SW-1:0] sub_cnt;
  logic [3:0]    sub_idx;
  logic [3:0]    bright_latched;

  logic [3:0] digit_val   [NUM_DIGITS];
  logic       digit_dp    [NUM_DIGITS];
  logic       digit_blank [NUM_DIGITS];

  logic                  slot_start;
  logic                  sub_end;
  logic                  slot_end;
  logic                  wr_ok;
  logic [3:0]            cur_val;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lit;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] anode_nxt;

  assign slot_start = (sub_cnt == '0) && (sub_idx == 4'd0);
  assign sub_end    = (sub_cnt == SUB_LAST);
  assign slot_end   = sub_end && (sub_idx == 4'hF);
  assign wr_ok      = wr_en && (32'(wr_sel) < NUM_DIGITS);

  assign cur_val   = digit_val[scan_idx];
  assign cur_dp    = digit_dp[scan_idx];
  assign cur_blank = digit_blank[scan_idx];
  assign lit       = (sub_idx <= bright_latched) && !cur_blank;

  // Slot/sub-period counters, digit index, frame pulse and brightness latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sub_cnt        <= '0;
      sub_idx        <= 4'd0;
      scan_idx       <= '0;
      frame_tick     <= 1'b0;
      bright_latched <= 4'hF;
    end else begin
      frame_tick <= 1'b0;
      if (slot_start) begin
        bright_latched <= bright;
      end
      if (sub_end) begin
        sub_cnt <= '0;
        sub_idx <= sub_idx + 4'd1;
      end else begin
        sub_cnt <= sub_cnt + SW'(1);
      end
      if (slot_end) begin
        if (scan_idx == IDX_LAST) begin
          scan_idx   <= '0;
          frame_tick <= 1'b1;
        end else begin
          scan_idx <= scan_idx + IW'(1);
        end
      end
    end
  end

  // Digit register file; out-of-range selects are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        digit_val[i]   <= 4'd0;
        digit_dp[i]    <= 1'b0;
        digit_blank[i] <= 1'b0;
      end
    end else if (wr_ok) begin
      digit_val[wr_sel]   <= wr_data;
      digit_dp[wr_sel]    <= wr_dp;
      digit_blank[wr_sel] <= wr_blank;
    end
  end

  // Hex to segment pattern {g,f,e,d,c,b,a}, active-high lit.
  always_comb begin
    seg = 7'h00;
    case (cur_val)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  // One-hot-low anode select for the scanned digit when lit.
  always_comb begin
    anode_nxt = '1;
    if (lit) begin
      anode_nxt[scan_idx] = 1'b0;
    end
  end

  // Registered display drive, one cycle behind the counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode   <= '1;
      cathode <= SEG_INV;
      dp      <= SEG_ACTIVE_LOW;
    end else begin
      anode   <= anode_nxt;
      cathode <= (lit ? seg : 7'h00) ^ SEG_INV;
      dp      <= (lit && cur_dp) ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl at NUM_DIGITS=5, REFRESH_DIV=32.
// Edge n counts rising edges since reset release (first edge is n=0);
// outputs sampled 1 time unit after edge n reflect slot-counter value n.
module tb_sevenseg_scan_ctrl;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic [3:0] bright;

  logic [4:0] anode,      anode_al;
  logic [6:0] cathode,    cathode_al;
  logic       dp,         dp_al;
  logic [2:0] scan_idx,   scan_idx_al;
  logic       frame_tick, frame_tick_al;

  int n_cmp;
  int n_bad;
  int n;

  sevenseg_scan_ctrl #(.NUM_DIGITS(5), .REFRESH_DIV(32), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .bright(bright), .anode(anode),
    .cathode(cathode), .dp(dp), .scan_idx(scan_idx), .frame_tick(frame_tick)
  );

  sevenseg_scan_ctrl #(.NUM_DIGITS(5), .REFRESH_DIV(32), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .bright(bright), .anode(anode_al),
    .cathode(cathode_al), .dp(dp_al), .scan_idx(scan_idx_al), .frame_tick(frame_tick_al)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [4:0] ea, input logic [6:0] ec,
                          input logic ed);
    chk({tag, ".anode"}, 32'(anode), 32'(ea));
    chk({tag, ".cathode"}, 32'(cathode), 32'(ec));
    chk({tag, ".dp"}, 32'(dp), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    n = n + 1;
  endtask

  task automatic goto(input int t);
    while (n < t) tick();
  endtask

  task automatic wr(input logic [2:0] sel, input logic [3:0] data, input logic dpv,
                    input logic blk);
    wr_en    = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    wr_dp    = dpv;
    wr_blank = blk;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    n = -1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    n        = -1;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_sel   = 3'd0;
    wr_data  = 4'd0;
    wr_dp    = 1'b0;
    wr_blank = 1'b0;
    bright   = 4'hF;

    // Reset state on both polarities.
    repeat (2) @(posedge clock);
    #1;
    chk_disp("rst", 5'b11111, 7'h00, 1'b0);
    chk("rst.scan_idx", 32'(scan_idx), 32'd0);
    chk("rst.frame_tick", 32'(frame_tick), 32'd0);
    chk("rst_al.cathode", 32'(cathode_al), 32'h7F);
    chk("rst_al.dp", 32'(dp_al), 32'd1);
    release_reset();

    // Free-running scan of all-zero digits.
    goto(0);   chk_disp("s0", 5'b11110, 7'h3F, 1'b0);
    chk("s0.scan_idx", 32'(scan_idx), 32'd0);
    goto(31);  chk_disp("s0end", 5'b11110, 7'h3F, 1'b0);
    chk("s1.scan_idx", 32'(scan_idx), 32'd1);
    goto(32);  chk_disp("s1", 5'b11101, 7'h3F, 1'b0);
    goto(69);  chk_disp("s2", 5'b11011, 7'h3F, 1'b0);
    chk("s2.scan_idx", 32'(scan_idx), 32'd2);
    goto(100); chk_disp("s3", 5'b10111, 7'h3F, 1'b0);
    goto(130); chk_disp("s4", 5'b01111, 7'h3F, 1'b0);
    chk("s4.scan_idx", 32'(scan_idx), 32'd4);
    goto(158); chk("ft.before", 32'(frame_tick), 32'd0);
    goto(159); chk("ft.pulse", 32'(frame_tick), 32'd1);
    chk("ft.scan_idx", 32'(scan_idx), 32'd0);
    goto(160); chk("ft.after", 32'(frame_tick), 32'd0);
    chk_disp("wrap", 5'b11110, 7'h3F, 1'b0);

    // Digit 3 = A with dp.
    wr(3'd3, 4'hA, 1'b1, 1'b0);
    goto(230); chk_disp("d3.slot2", 5'b11011, 7'h3F, 1'b0);
    goto(260); chk_disp("d3.slot3", 5'b10111, 7'h77, 1'b1);

    // Blank digit 2; out-of-range select ignored.
    wr(3'd2, 4'h5, 1'b1, 1'b1);
    wr(3'd6, 4'h9, 1'b1, 1'b0);
    wr(3'd7, 4'h8, 1'b1, 1'b0);
    goto(330); chk_disp("oor.slot0", 5'b11110, 7'h3F, 1'b0);
    goto(360); chk_disp("oor.slot1", 5'b11101, 7'h3F, 1'b0);
    goto(390); chk_disp("blank.slot2", 5'b11111, 7'h00, 1'b0);
    goto(420); chk_disp("d3.again", 5'b10111, 7'h77, 1'b1);

    // Brightness: mid-slot change waits for the next slot.
    goto(450); bright = 4'd3;
    goto(470); chk_disp("br.midslot", 5'b01111, 7'h3F, 1'b0);
    goto(487); chk_disp("br3.on", 5'b11110, 7'h3F, 1'b0);
    goto(488); chk_disp("br3.off", 5'b11111, 7'h00, 1'b0);
    goto(490); bright = 4'hF;
    goto(500); chk_disp("br.stay_off", 5'b11111, 7'h00, 1'b0);
    goto(530); chk_disp("br15.next", 5'b11101, 7'h3F, 1'b0);
    bright = 4'd0;
    goto(577); chk_disp("br0.on", 5'b10111, 7'h77, 1'b1);
    goto(578); chk_disp("br0.off", 5'b11111, 7'h00, 1'b0);
    bright = 4'hF;

    // Write to the digit being scanned: old content one more cycle.
    goto(615);
    wr(3'd4, 4'h7, 1'b0, 1'b0);
    chk("live.scan_idx", 32'(scan_idx), 32'd4);
    chk_disp("live.old", 5'b01111, 7'h3F, 1'b0);
    goto(617); chk_disp("live.new", 5'b01111, 7'h07, 1'b0);

    // Active-low segment polarity with digit 8.
    wr(3'd0, 4'h8, 1'b0, 1'b0);
    goto(650);
    chk_disp("d0.eight", 5'b11110, 7'h7F, 1'b0);
    chk("al.cathode", 32'(cathode_al), 32'h00);
    chk("al.dp", 32'(dp_al), 32'd1);
    chk("al.anode", 32'(anode_al), 32'(5'b11110));

    // Reset mid-frame with a write in flight.
    goto(660);
    wr_en   = 1'b1;
    wr_sel  = 3'd1;
    wr_data = 4'h5;
    wr_dp   = 1'b1;
    reset   = 1'b1;
    #1;
    chk_disp("rst2", 5'b11111, 7'h00, 1'b0);
    chk("rst2.scan_idx", 32'(scan_idx), 32'd0);
    chk("rst2.frame_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(posedge clock);
    wr_en = 1'b0;
    release_reset();
    goto(0);   chk_disp("rst2.d0", 5'b11110, 7'h3F, 1'b0);
    goto(40);  chk_disp("rst2.d1", 5'b11101, 7'h3F, 1'b0);
    goto(100); chk_disp("rst2.d3", 5'b10111, 7'h3F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 131072, clock cycles per digit slot (multiple of 16, >=16).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0; 0 = cathode/dp bit 1 lights the segment, 1 = all segment outputs inverted.
REQ-004 SHALL have port clock  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write strobe for the digit register file.
REQ-007 SHALL have port wr_sel  input  IW=$clog2(NUM_DIGITS)  target digit index.
REQ-008 SHALL have port wr_data  input  4  hex value for the target digit.
REQ-009 SHALL have port wr_dp  input  1  decimal-point enable for the target digit.
REQ-010 SHALL have port wr_blank  input  1  blank flag for the target digit.
REQ-011 SHALL have port bright  input  4  brightness level, sampled at each slot start.
REQ-012 SHALL have port anode  output  NUM_DIGITS  digit enables, active-low.
REQ-013 SHALL have port cathode  output  7  segments {g,f,e,d,c,b,a}.
REQ-014 SHALL have port dp  output  1  decimal-point segment.
REQ-015 SHALL have port scan_idx  output  IW  index of the digit currently scanned.
REQ-016 SHALL have port frame_tick  output  1  one-cycle pulse at completion of a full scan frame.

Function
REQ-017 SHALL hold per digit a 4-bit value, dp bit and blank bit; when wr_en=1 and wr_sel<NUM_DIGITS, all three SHALL update at the clock edge; wr_sel>=NUM_DIGITS SHALL be ignored.
REQ-018 Writes SHALL NOT override the scan; new content SHALL appear on outputs the next time that digit is scanned (or, if currently scanned, 2 cycles after the write edge).
REQ-019 Slot counter SHALL count 0..REFRESH_DIV-1; at terminal count it SHALL wrap to 0 and scan_idx SHALL increment, wrapping NUM_DIGITS-1 -> 0 (no unused indices for non-power-of-2 counts).
REQ-020 frame_tick SHALL be 1 for exactly the cycle in which scan_idx changes from NUM_DIGITS-1 to 0.
REQ-021 Each slot SHALL be divided into 16 sub-periods of REFRESH_DIV/16 cycles; the scanned digit SHALL be enabled during sub-periods 0..bright_latched and disabled in the remainder (bright=15 -> 100%, bright=0 -> 1/16).
REQ-022 bright SHALL be latched at slot-counter value 0; changes mid-slot SHALL take effect from the next slot.
REQ-023 anode SHALL have at most one bit low; the low bit SHALL be anode[scan_idx] when enabled per REQ-021 and the digit is not blank; otherwise all ones.
REQ-024 cathode encoding (SEG_ACTIVE_LOW=0), hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-025 Blank or disabled digit SHALL drive cathode and dp to the inactive level (0 for SEG_ACTIVE_LOW=0).
REQ-026 anode, cathode, dp SHALL be registered, lagging scan_idx/slot counter by exactly 1 cycle; frame_tick and scan_idx SHALL be registered outputs of the counters.
REQ-027 Simultaneous write to and scan of the same digit SHALL display old content that cycle, new content thereafter; no glitch combination of old/new fields.

Reset
REQ-028 During reset: slot counter 0, scan_idx 0, frame_tick 0, bright_latched 15, anode all ones, cathode and dp inactive.
REQ-029 Reset SHALL clear all digit values to 0, dp to 0, blank to 0 (display shows all zeros after release).
REQ-030 Reset asserted mid-slot or mid-write SHALL take effect immediately and discard the in-flight write.

Verification (NUM_DIGITS=5, REFRESH_DIV=32)
REQ-031 Release reset, no writes -> anode cycles 11110,11101,11011,10111,01111 each 32 cycles, cathode 3F; frame_tick every 160 cycles.
REQ-032 Write digit 3 = A with dp=1 -> during slot 3 cathode=77, dp=1; other slots unchanged.
REQ-033 bright=3 -> anode low 8 of 32 cycles per slot; bright change mid-slot applies next slot only.
REQ-034 Write digit 2 blank=1 -> anode all ones and cathode 00 for slot 2; wr_sel=6 -> no register change.
REQ-035 Write to digit currently scanned -> output changes 2 cycles after write edge; reset mid-frame -> anode all ones, scan_idx 0 immediately.
REQ-036 SEG_ACTIVE_LOW=1, digit 8 -> cathode 00, dp 1.
